// File: rtl/uart_recv_if.sv
// uart_recv_if: bundle of the serial receiver's pin and byte-side signals.
//   rx        : serial line into the receiver (idle high)
//   data      : last correctly framed byte
//   valid     : one-cycle strobe, data updated
//   frame_err : one-cycle strobe, stop bit sampled low
//   busy      : a frame is being received
// master : side that drives the line and consumes bytes (board/testbench)
// slave  : the receiver itself
interface uart_recv_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   modport master (
      output rx,
      input  data,
      input  valid,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  rx,
      output data,
      output valid,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with a fixed baud divider.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : uart_recv_if.slave -- rx in; data/valid/frame_err/busy out
// Each frame is sampled at mid-bit, timed from the detected start edge. A good stop bit
// updates data and pulses valid; a low stop bit pulses frame_err and leaves data alone.
module uart_recv #(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned BAUD_DIV  = CLK_FREQ / BAUD_RATE,
   parameter int unsigned HALF_DIV  = BAUD_DIV / 2
) (
   input logic        clk,
   input logic        rst,
   uart_recv_if.slave bus
);

   localparam logic [13:0] BaudLast = 14'(BAUD_DIV - 1);
   localparam logic [13:0] HalfLast = 14'(HALF_DIV - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e      state_q, state_d;
   logic        rx_meta_q, rx_meta_d;
   logic        rx_s_q, rx_s_d;
   logic        rx_d_q, rx_d_d;
   logic [13:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  sh_q, sh_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        frame_err_q, frame_err_d;
   logic        busy_q, busy_d;

   always_comb begin
      rx_meta_d   = bus.rx;
      rx_s_d      = rx_meta_q;
      rx_d_d      = rx_s_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      sh_d        = sh_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      busy_d      = busy_q;

      case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            // Falling edge only: a line stuck low never retriggers.
            if (rx_d_q && !rx_s_q) begin
               state_d = StStart;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         StStart: begin
            cnt_d = cnt_q + 14'd1;
            if (cnt_q == HalfLast) begin
               if (!rx_s_q) begin
                  state_d = StData;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  // Start bit gone high by mid-bit: treat as a glitch.
                  state_d = StIdle;
                  busy_d  = 1'b0;
               end
            end
         end
         StData: begin
            cnt_d = cnt_q + 14'd1;
            if (cnt_q == BaudLast) begin
               sh_d  = {rx_s_q, sh_q[7:1]};
               cnt_d = '0;
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            cnt_d = cnt_q + 14'd1;
            if (cnt_q == BaudLast) begin
               if (rx_s_q) begin
                  data_d  = sh_q;
                  valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               // Leave at mid-stop so a back-to-back start edge is still caught.
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_d_q      <= 1'b1;
         cnt_q       <= '0;
         idx_q       <= '0;
         sh_q        <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         rx_d_q      <= rx_d_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sh_q        <= sh_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: scoreboard bench for uart_recv at a reduced divider (17 clk/bit).
// The driver serialises bytes on rx and queues the expected strobe (kind, byte, cycle);
// a negedge monitor pops and compares whenever valid or frame_err is seen.
module tb_uart_recv;
   localparam int unsigned CLK_FREQ  = 1_700_000;
   localparam int unsigned BAUD_RATE = 100_000;
   localparam int unsigned BAUD      = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF      = BAUD / 2;
   // Pin change after edge N: 2 sync stages + edge register, then half bit + 9 bits.
   localparam int unsigned LAT       = 3 + HALF + 9 * BAUD;

   typedef struct {
      bit          err;
      logic [7:0]  d;
      int unsigned at;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;
   uart_recv_if bus ();

   exp_t        sb[$];
   exp_t        e;
   int          checks = 0;
   int          passes = 0;
   int          strobe_cnt = 0;
   logic [7:0]  last_good = 8'h00;
   logic        busy_prev = 1'b0;
   int unsigned busy_rise = 0;
   int unsigned busy_fall = 0;

   uart_recv #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         busy_prev = 1'b0;
      end else begin
         if (bus.busy && !busy_prev) busy_rise = cyc;
         if (!bus.busy && busy_prev) busy_fall = cyc;
         busy_prev = bus.busy;
         if (bus.valid || bus.frame_err) begin
            strobe_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_strobe", {30'd0, bus.valid, bus.frame_err}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("strobe_kind", {30'd0, bus.valid, bus.frame_err}, e.err ? 32'd1 : 32'd2);
               check("strobe_cycle", cyc, e.at);
               if (!e.err) last_good = e.d;
               check("data", {24'd0, bus.data}, {24'd0, last_good});
            end
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Send one 8N1 frame; abort_bit >= 0 stops driving halfway through that data bit.
   task automatic send(input logic [7:0] b, input bit stop, input int abort_bit);
      int unsigned n;
      exp_t x;
      n = cyc;
      bus.rx = 1'b0;
      if (abort_bit < 0) begin
         x.err = !stop;
         x.d   = b;
         x.at  = n + LAT;
         sb.push_back(x);
      end
      tick(BAUD);
      for (int i = 0; i < 8; i++) begin
         if (i == abort_bit) begin
            bus.rx = b[i];
            tick(BAUD / 2);
            return;
         end
         bus.rx = b[i];
         tick(BAUD);
      end
      bus.rx = stop;
      tick(BAUD);
      bus.rx = 1'b1;
      check("busy_fall_at_strobe", busy_fall, n + LAT);
   endtask

   task automatic glitch(input int unsigned len);
      int unsigned n;
      busy_rise = 0;
      busy_fall = 0;
      n = cyc;
      bus.rx = 1'b0;
      tick(len);
      bus.rx = 1'b1;
      tick(HALF + 10);
      check("glitch_busy_rise", busy_rise, n + 3);
      check("glitch_busy_fall", busy_fall, n + 3 + HALF);
   endtask

   initial begin
      int unsigned r;
      bus.rx = 1'b1;
      rst    = 1'b1;
      tick(3);
      check("rst_data", {24'd0, bus.data}, 32'd0);
      check("rst_valid", {31'd0, bus.valid}, 32'd0);
      check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      rst = 1'b0;
      tick(20 * BAUD);
      check("idle_no_strobe", strobe_cnt, 32'd0);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
      check("idle_data", {24'd0, bus.data}, 32'd0);

      send(8'h55, 1'b1, -1);
      tick(BAUD);
      send(8'hA3, 1'b1, -1);
      send(8'h3C, 1'b1, -1);
      tick(BAUD);
      glitch(3);
      send(8'h7E, 1'b1, -1);
      tick(BAUD);
      send(8'h12, 1'b1, -1);
      send(8'h81, 1'b0, -1);
      tick(BAUD);
      send(8'hF0, 1'b1, -1);
      tick(BAUD);

      send(8'hC6, 1'b1, 4);
      rst = 1'b1;
      #1;
      check("midrst_data", {24'd0, bus.data}, 32'd0);
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      last_good = 8'h00;
      bus.rx = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2 * BAUD);
      check("post_rst_sb", sb.size(), 32'd0);
      send(8'h09, 1'b1, -1);
      tick(BAUD);

      for (int k = 0; k < 30; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) glitch($urandom_range(1, HALF - 1));
         else send(8'($urandom), r != 1, -1);
         tick($urandom_range(0, 2 * BAUD));
      end

      tick(2 * BAUD);
      check("sb_drained", sb.size(), 32'd0);
      check("final_data", {24'd0, bus.data}, {24'd0, last_good});
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
